// File: rtl/mem_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int WORD_BYTES = 4;

  // Byte enables only reach the memory while a write strobe is active.
  function automatic logic [WORD_BYTES-1:0] be_gate(input logic en,
                                                    input logic [WORD_BYTES-1:0] be);
    logic [WORD_BYTES-1:0] res;
    if (en) begin
      res = be;
    end else begin
      res = {WORD_BYTES{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the fetch port was refused.
module starve_counter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is guaranteed a
// grant after MAX_WAIT consecutive refusals. Read data returns one cycle later.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        if_req,
  input  logic [31:2] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:2] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_read_ready,
  output logic        mem_write_ready,
  output logic [31:2] mem_read_address,
  output logic [31:2] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte,
  input  logic [31:0] mem_read_data
);

  owner_e           owner_q;
  owner_e           owner_d;
  logic             starve_sat_s;
  logic [CNT_W-1:0] starve_cnt_s;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk    (clk),
    .resetb (resetb),
    .inc_i  (if_req & ~if_gnt),
    .clr_i  (if_gnt | ~if_req),
    .cnt_o  (starve_cnt_s),
    .sat_o  (starve_sat_s)
  );

  // Grant selection and memory steering; everything is forced idle in reset.
  always_comb begin
    if_gnt            = 1'b0;
    d_gnt             = 1'b0;
    mem_read_ready    = 1'b0;
    mem_write_ready   = 1'b0;
    mem_read_address  = 30'd0;
    mem_write_address = 30'd0;
    mem_write_data    = 32'd0;
    owner_d           = OWN_IDLE;

    if (!resetb) begin
      if_gnt = 1'b0;
    end else if (if_req && (!d_req || starve_sat_s)) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
    end

    if (if_gnt) begin
      mem_read_ready   = 1'b1;
      mem_read_address = if_addr;
      owner_d          = OWN_IF;
    end else if (d_gnt && !d_we) begin
      mem_read_ready   = 1'b1;
      mem_read_address = d_addr;
      owner_d          = OWN_D;
    end else if (d_gnt) begin
      mem_write_ready   = 1'b1;
      mem_write_address = d_addr;
      mem_write_data    = d_wdata;
    end else begin
      owner_d = OWN_IDLE;
    end

    mem_write_byte = be_gate(mem_write_ready, d_be);
  end

  // Owner of the read data returning next cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = mem_read_data;
  assign d_rdata   = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a behavioural memory
// and a transaction-level reference model of arbitration and memory contents.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        if_req, d_req, d_we;
  logic [31:2] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_read_ready, mem_write_ready;
  logic [31:2] mem_read_address, mem_write_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic [3:0]  mem_write_byte;

  logic [31:0] mem_arr [0:255];
  logic        bk_we;
  logic [7:0]  bk_addr;
  logic [31:0] bk_data;

  logic [31:0] ref_mem [0:255];
  int          wait_cnt;
  bit          last_if_g, last_d_g;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .resetb(resetb),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_byte(mem_write_byte),
    .mem_read_data(mem_read_data)
  );

  // Behavioural single-port memory with 1-cycle read latency and a backdoor loader.
  always @(posedge clk) begin
    if (bk_we) begin
      mem_arr[bk_addr] <= bk_data;
    end else if (mem_write_ready) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_byte[b]) mem_arr[mem_write_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
    if (mem_read_ready) mem_read_data <= mem_arr[mem_read_address[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: entered just after a falling edge with inputs set.
  task automatic step();
    bit eg_if, eg_d, rd_d, wr_d;
    logic [7:0] ia, da;
    #1;
    eg_if = if_req && (!d_req || wait_cnt == MAX_WAIT);
    eg_d  = d_req && !eg_if;
    rd_d  = eg_d && !d_we;
    wr_d  = eg_d && d_we;
    ia    = if_addr[9:2];
    da    = d_addr[9:2];
    check("if_gnt", if_gnt, eg_if);
    check("d_gnt", d_gnt, eg_d);
    check("rd_ready", mem_read_ready, eg_if || rd_d);
    check("wr_ready", mem_write_ready, wr_d);
    check("wr_byte", mem_write_byte, wr_d ? d_be : 4'h0);
    if (eg_if) check("rd_addr_if", mem_read_address, if_addr);
    if (rd_d)  check("rd_addr_d", mem_read_address, d_addr);
    if (wr_d) begin
      check("wr_addr", mem_write_address, d_addr);
      check("wr_data", mem_write_data, d_wdata);
      for (int b = 0; b < 4; b++)
        if (d_be[b]) ref_mem[da][8*b +: 8] = d_wdata[8*b +: 8];
    end
    if (if_req && !eg_if) wait_cnt = (wait_cnt < MAX_WAIT) ? wait_cnt + 1 : MAX_WAIT;
    else wait_cnt = 0;
    @(posedge clk);
    #1;
    check("if_rvalid", if_rvalid, eg_if);
    check("d_rvalid", d_rvalid, rd_d);
    if (eg_if) check("if_rdata", if_rdata, ref_mem[ia]);
    if (rd_d)  check("d_rdata", d_rdata, ref_mem[da]);
    last_if_g = eg_if;
    last_d_g  = eg_d;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] pattern;
    resetb = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 30'd0; d_addr = 30'd0; d_wdata = 32'd0; d_be = 4'h0;
    bk_we = 1'b0; bk_addr = 8'd0; bk_data = 32'd0; wait_cnt = 0;
    last_if_g = 1'b1; last_d_g = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      bk_we = 1'b1; bk_addr = 8'(i);
      bk_data = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0F0F;
      if (i == 32'h10) bk_data = 32'hDEAD_BEEF;
      if (i == 32'h20) bk_data = 32'hAAAA_AAAA;
      ref_mem[i] = bk_data;
      @(negedge clk);
    end
    bk_we = 1'b0;
    resetb = 1'b1;

    // Fetch only, granted in the first cycle out of reset.
    if_req = 1'b1; if_addr = 30'h10;
    step();
    check("t1_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;

    // Partial write then read-back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_be = 4'b0011; d_wdata = 32'h1234_5678;
    step();
    d_we = 1'b0;
    step();
    check("t2_rdata", d_rdata, 32'hAAAA_5678);
    d_req = 1'b0;

    // Continuous contention: fetch every fifth cycle.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 30'h5; d_addr = 30'h6;
    for (int c = 0; c < 10; c++) begin
      step();
      pattern[c] = last_if_g;
    end
    check("t3_pattern", 32'(pattern), 32'h210);
    if_req = 1'b0; d_req = 1'b0;

    // Back-to-back fetches.
    if_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      if_addr = 30'(a);
      step();
    end
    if_req = 1'b0;

    // Idle cycles.
    step();
    step();

    // Reset right after a data read grant while fetch is partly starved.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 30'h3; d_addr = 30'h4;
    repeat (3) step();
    #1;
    check("t5_pre_dgnt", d_gnt, 1'b1);
    @(posedge clk);
    #1;
    resetb = 1'b0; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hCAFE_F00D;
    #1;
    check("t5_d_rvalid", d_rvalid, 1'b0);
    check("t5_if_rvalid", if_rvalid, 1'b0);
    check("t5_if_gnt", if_gnt, 1'b0);
    check("t5_d_gnt", d_gnt, 1'b0);
    check("t5_rd_ready", mem_read_ready, 1'b0);
    check("t5_wr_ready", mem_write_ready, 1'b0);
    check("t5_wr_byte", mem_write_byte, 4'h0);
    check("t5_rd_addr", mem_read_address, 30'd0);
    check("t5_wr_addr", mem_write_address, 30'd0);
    check("t5_wr_data", mem_write_data, 32'd0);
    @(negedge clk);
    #1;
    check("t5_rst_d_rvalid", d_rvalid, 1'b0);
    resetb = 1'b1; wait_cnt = 0; d_we = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      pattern[c] = last_if_g;
    end
    check("t5_post_pattern", 32'(pattern[4:0]), 32'h10);

    // Randomized traffic; a requester holds its request until granted.
    if_req = 1'b0; d_req = 1'b0; last_if_g = 1'b1; last_d_g = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!if_req || last_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 30'($urandom_range(0, 63));
      end
      if (!d_req || last_d_g) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 30'($urandom_range(0, 63));
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
